// File: rtl/jtag_tap_pkg.sv
// Shared TAP types: controller state encoding, opcodes, register widths and decode bundle.
// The JTAG_IDCODE_EN macro enables the ID register and IDCODE opcode in jtag_tap_ctrl.
package jtag_tap_pkg;

  localparam int unsigned IR_W = 4;
  localparam int unsigned ID_W = 32;

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI,
    ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAU_DR, ST_EX2_DR, ST_UPD_DR,
    ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAU_IR, ST_EX2_IR, ST_UPD_IR
  } tap_state_e;

  localparam logic [IR_W-1:0] OP_EXTEST  = 4'b0000;
  localparam logic [IR_W-1:0] OP_SAMPLE  = 4'b0001;
  localparam logic [IR_W-1:0] OP_IDCODE  = 4'b0010;
  localparam logic [IR_W-1:0] OP_BYPASS  = 4'b1111;
  localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;

  typedef enum logic [1:0] {DR_BSR, DR_BYPASS, DR_ID} dr_sel_e;

  // Per-cycle state decode handed from the FSM to the datapath.
  typedef struct packed {
    logic tlr_next;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
  } tap_dec_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller; exports a decode of the registered state.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic     CK,
  input  logic     RST,
  input  logic     TMS,
  output tap_dec_t dec_c
);

  tap_state_e state;
  tap_state_e state_nxt;

  always_ff @(posedge CK) begin
    if (RST) state <= ST_TLR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_TLR:    state_nxt = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    state_nxt = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_nxt = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_nxt = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_nxt = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_nxt = TMS ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: state_nxt = TMS ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: state_nxt = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_nxt = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_nxt = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_nxt = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_nxt = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_nxt = TMS ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: state_nxt = TMS ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: state_nxt = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_nxt = TMS ? ST_SEL_DR : ST_RTI;
      default:   state_nxt = ST_TLR;
    endcase
  end

  // tlr_next lets the IR reset coincide with entry into Test-Logic-Reset.
  always_comb begin
    dec_c            = '0;
    dec_c.tlr_next   = (state_nxt == ST_TLR);
    dec_c.capture_ir = (state == ST_CAP_IR);
    dec_c.shift_ir   = (state == ST_SH_IR);
    dec_c.update_ir  = (state == ST_UPD_IR);
    dec_c.capture_dr = (state == ST_CAP_DR);
    dec_c.shift_dr   = (state == ST_SH_DR);
    dec_c.update_dr  = (state == ST_UPD_DR);
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP top: instruction register, bypass/ID data registers and BSR control decode.
// Define JTAG_IDCODE_EN to build the 32-bit ID register and the IDCODE instruction.
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter logic [ID_W-1:0] IDCODE_VALUE = 32'h1234_5001
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            TMS,
  input  logic            TDI,
  input  logic            TDO_BSR,
  output logic            TDO,
  output logic            TDO_EN,
  output logic            clockdr,
  output logic            shiftdr,
  output logic            updatedr,
  output logic            bs_en,
  output logic [IR_W-1:0] ir_out
);

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] IR_TLR = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_TLR = OP_BYPASS;
`endif

  tap_dec_t        dec_c;
  logic [IR_W-1:0] ir_sr;
  logic            bypass_bit;
  logic            id_tdo_c;
  dr_sel_e         dr_sel_c;
  logic            bsr_sel_c;

  jtag_tap_fsm u_fsm (
    .CK    (CK),
    .RST   (RST),
    .TMS   (TMS),
    .dec_c (dec_c)
  );

  // IR shift stage: captures the fixed pattern, shifts LSB-first toward TDO.
  always_ff @(posedge CK) begin
    if (RST || dec_c.capture_ir) ir_sr <= IR_CAPTURE;
    else if (dec_c.shift_ir)     ir_sr <= {TDI, ir_sr[IR_W-1:1]};
  end

  always_ff @(posedge CK) begin
    if (RST || dec_c.tlr_next) ir_out <= IR_TLR;
    else if (dec_c.update_ir)  ir_out <= ir_sr;
  end

  always_comb begin
    dr_sel_c = DR_BYPASS;
    case (ir_out)
      OP_EXTEST, OP_SAMPLE: dr_sel_c = DR_BSR;
`ifdef JTAG_IDCODE_EN
      OP_IDCODE:            dr_sel_c = DR_ID;
`endif
      OP_BYPASS:            dr_sel_c = DR_BYPASS;
      default:              dr_sel_c = DR_BYPASS;
    endcase
  end

  assign bsr_sel_c = (dr_sel_c == DR_BSR);

  always_ff @(posedge CK) begin
    if (RST || dec_c.capture_dr) bypass_bit <= 1'b0;
    else if (dec_c.shift_dr)     bypass_bit <= TDI;
  end

`ifdef JTAG_IDCODE_EN
  logic [ID_W-1:0] id_sr;

  always_ff @(posedge CK) begin
    if (RST || dec_c.capture_dr)                  id_sr <= IDCODE_VALUE;
    else if (dec_c.shift_dr && dr_sel_c == DR_ID) id_sr <= {TDI, id_sr[ID_W-1:1]};
  end

  assign id_tdo_c = id_sr[0];
`else
  wire [ID_W-1:0] unused_idcode = IDCODE_VALUE;
  assign id_tdo_c = 1'b0;
`endif

  // All control outputs derive from the registered TAP state, never from TMS.
  always_comb begin
    TDO      = 1'b0;
    TDO_EN   = dec_c.shift_ir | dec_c.shift_dr;
    clockdr  = bsr_sel_c & (dec_c.capture_dr | dec_c.shift_dr);
    shiftdr  = dec_c.shift_dr;
    updatedr = bsr_sel_c & dec_c.update_dr;
    bs_en    = (ir_out == OP_EXTEST);
    if (dec_c.shift_ir) begin
      TDO = ir_sr[0];
    end else if (dec_c.shift_dr) begin
      case (dr_sel_c)
        DR_BSR:    TDO = TDO_BSR;
        DR_BYPASS: TDO = bypass_bit;
        DR_ID:     TDO = id_tdo_c;
        default:   TDO = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: vector table, directed corner sequences and
// randomized TMS/TDI traffic checked against a transaction-level TAP model.
module tb_jtag_tap_ctrl;

  localparam logic [31:0] IDV = 32'h1234_5001;
`ifdef JTAG_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  localparam logic [3:0] TLR_IR = ID_EN ? 4'b0010 : 4'b1111;

  // Reference model state names (bench-local numbering).
  localparam int M_TLR = 0, M_RTI = 1;
  localparam int M_SDR = 2, M_CDR = 3, M_SHDR = 4, M_E1DR = 5, M_PDR = 6, M_E2DR = 7, M_UDR = 8;
  localparam int M_SIR = 9, M_CIR = 10, M_SHIR = 11, M_E1IR = 12, M_PIR = 13, M_E2IR = 14, M_UIR = 15;

  logic       CK = 1'b0;
  logic       RST = 1'b1, TMS = 1'b1, TDI = 1'b0, TDO_BSR = 1'b0;
  logic       TDO, TDO_EN, clockdr, shiftdr, updatedr, bs_en;
  logic [3:0] ir_out;

  jtag_tap_ctrl #(.IDCODE_VALUE(IDV)) dut (
    .CK(CK), .RST(RST), .TMS(TMS), .TDI(TDI), .TDO_BSR(TDO_BSR),
    .TDO(TDO), .TDO_EN(TDO_EN), .clockdr(clockdr), .shiftdr(shiftdr),
    .updatedr(updatedr), .bs_en(bs_en), .ir_out(ir_out)
  );

  always #5 CK = ~CK;

  int n_cmp = 0;
  int n_bad = 0;

  int       nxt [16][2];
  int       m_st = M_TLR;
  bit [3:0] m_ir = 4'b0;
  bit [3:0] m_ir_sr = 4'b0001;
  bit       m_dr_q[$];
  bit       m_valid = 1'b0;
  logic     last_tdo;

  typedef struct {
    bit       tms;
    bit       tdi;
    bit       bsr;
    bit [4:0] exp;   // {TDO, TDO_EN, clockdr, shiftdr, updatedr}
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(bit tms, bit tdi, bit bsr, bit [4:0] exp);
    vec_t v;
    v.tms = tms; v.tdi = tdi; v.bsr = bsr; v.exp = exp;
    return v;
  endfunction

  // 0 = boundary scan, 1 = bypass, 2 = ID
  function automatic int sel_kind(bit [3:0] ir);
    if (ir == 4'd0 || ir == 4'd1) return 0;
    if (ir == 4'd2 && ID_EN) return 2;
    return 1;
  endfunction

  task automatic chk1(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_check();
    int k;
    bit e_tdo;
    k = sel_kind(m_ir);
    e_tdo = 1'b0;
    if (m_st == M_SHIR) e_tdo = m_ir_sr[0];
    else if (m_st == M_SHDR) begin
      if (k == 0) e_tdo = TDO_BSR;
      else if (m_dr_q.size() > 0) e_tdo = m_dr_q[0];
    end
    chk1("m_tdo",      32'(TDO),      32'(e_tdo));
    chk1("m_tdo_en",   32'(TDO_EN),   32'(m_st == M_SHIR || m_st == M_SHDR));
    chk1("m_clockdr",  32'(clockdr),  32'(k == 0 && (m_st == M_CDR || m_st == M_SHDR)));
    chk1("m_shiftdr",  32'(shiftdr),  32'(m_st == M_SHDR));
    chk1("m_updatedr", 32'(updatedr), 32'(k == 0 && m_st == M_UDR));
    chk1("m_bs_en",    32'(bs_en),    32'(m_ir == 4'd0));
    chk1("m_ir_out",   32'(ir_out),   32'(m_ir));
  endtask

  task automatic model_step(bit rst, bit tms, bit tdi);
    int k;
    if (rst) begin
      m_st = M_TLR; m_ir = TLR_IR; m_dr_q.delete(); m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    case (m_st)
      M_CIR:  m_ir_sr = 4'b0001;
      M_SHIR: m_ir_sr = (m_ir_sr >> 1) | (4'(tdi) << 3);
      M_UIR:  m_ir = m_ir_sr;
      M_CDR: begin
        m_dr_q.delete();
        k = sel_kind(m_ir);
        if (k == 1) m_dr_q.push_back(1'b0);
        if (k == 2) for (int i = 0; i < 32; i++) m_dr_q.push_back(IDV[i]);
      end
      M_SHDR: if (m_dr_q.size() > 0) begin
        void'(m_dr_q.pop_front());
        m_dr_q.push_back(tdi);
      end
      default: ;
    endcase
    m_st = nxt[m_st][tms];
    if (m_st == M_TLR) m_ir = TLR_IR;
  endtask

  task automatic cyc(bit rst, bit tms, bit tdi, bit bsr, bit dchk, bit [4:0] dexp, string dname);
    @(negedge CK);
    RST = rst; TMS = tms; TDI = tdi; TDO_BSR = bsr;
    #1;
    last_tdo = TDO;
    if (m_valid) model_check();
    if (dchk) chk1(dname, {27'd0, TDO, TDO_EN, clockdr, shiftdr, updatedr}, {27'd0, dexp});
    @(posedge CK);
    model_step(rst, tms, tdi);
  endtask

  task automatic t(bit tms);
    cyc(1'b0, tms, 1'b0, 1'b0, 1'b0, 5'd0, "");
  endtask

  task automatic load_ir(bit [3:0] v);
    for (int i = 0; i < 5; i++) t(1'b1);
    t(1'b0); t(1'b1); t(1'b1); t(1'b0); t(1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, i == 3, v[i], 1'b0, 1'b0, 5'd0, "");
    t(1'b1); t(1'b0);
  endtask

  initial begin
    logic [31:0] pat, got, exp_id;

    nxt[M_TLR]  = '{M_RTI,  M_TLR};  nxt[M_RTI]  = '{M_RTI,  M_SDR};
    nxt[M_SDR]  = '{M_CDR,  M_SIR};  nxt[M_CDR]  = '{M_SHDR, M_E1DR};
    nxt[M_SHDR] = '{M_SHDR, M_E1DR}; nxt[M_E1DR] = '{M_PDR,  M_UDR};
    nxt[M_PDR]  = '{M_PDR,  M_E2DR}; nxt[M_E2DR] = '{M_SHDR, M_UDR};
    nxt[M_UDR]  = '{M_RTI,  M_SDR};  nxt[M_SIR]  = '{M_CIR,  M_TLR};
    nxt[M_CIR]  = '{M_SHIR, M_E1IR}; nxt[M_SHIR] = '{M_SHIR, M_E1IR};
    nxt[M_E1IR] = '{M_PIR,  M_UIR};  nxt[M_PIR]  = '{M_PIR,  M_E2IR};
    nxt[M_E2IR] = '{M_SHIR, M_UIR};  nxt[M_UIR]  = '{M_RTI,  M_SDR};

    // Load EXTEST: captured 0001 leaves LSB-first as 1,0,0,0.
    vt.push_back(mk(0,0,0,5'b00000)); vt.push_back(mk(1,0,0,5'b00000));
    vt.push_back(mk(1,0,0,5'b00000)); vt.push_back(mk(0,0,0,5'b00000));
    vt.push_back(mk(0,0,0,5'b00000)); vt.push_back(mk(0,0,1,5'b11000));
    vt.push_back(mk(0,0,1,5'b01000)); vt.push_back(mk(0,0,1,5'b01000));
    vt.push_back(mk(1,0,1,5'b01000)); vt.push_back(mk(1,0,0,5'b00000));
    vt.push_back(mk(0,0,0,5'b00000));
    // EXTEST data scan: capture + 3 shifts + update; TDO follows TDO_BSR.
    vt.push_back(mk(1,0,0,5'b00000)); vt.push_back(mk(0,0,0,5'b00000));
    vt.push_back(mk(0,0,1,5'b00100)); vt.push_back(mk(0,1,1,5'b11110));
    vt.push_back(mk(0,1,0,5'b01110)); vt.push_back(mk(1,0,1,5'b11110));
    vt.push_back(mk(1,0,0,5'b00000)); vt.push_back(mk(0,0,0,5'b00001));
    vt.push_back(mk(0,0,0,5'b00000));
    // Load BYPASS (1111).
    vt.push_back(mk(1,0,0,5'b00000)); vt.push_back(mk(1,0,0,5'b00000));
    vt.push_back(mk(0,0,0,5'b00000)); vt.push_back(mk(0,0,0,5'b00000));
    vt.push_back(mk(0,1,0,5'b11000)); vt.push_back(mk(0,1,0,5'b01000));
    vt.push_back(mk(0,1,0,5'b01000)); vt.push_back(mk(1,1,0,5'b01000));
    vt.push_back(mk(1,0,0,5'b00000)); vt.push_back(mk(1,0,0,5'b00000));
    // BYPASS scan: TDI 1,0,1,1 -> TDO 0,1,0,1; BSR input driven opposite.
    vt.push_back(mk(0,0,0,5'b00000)); vt.push_back(mk(0,0,1,5'b00000));
    vt.push_back(mk(0,1,1,5'b01010)); vt.push_back(mk(0,0,0,5'b11010));
    vt.push_back(mk(0,1,1,5'b01010)); vt.push_back(mk(1,1,0,5'b11010));
    vt.push_back(mk(1,0,0,5'b00000)); vt.push_back(mk(0,0,0,5'b00000));

    // Reset state.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, "");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, "");
    #2;
    chk1("rst_ir_out", 32'(ir_out), 32'(TLR_IR));
    chk1("rst_ctrl", {26'd0, TDO, TDO_EN, clockdr, shiftdr, updatedr, bs_en}, 32'd0);

    foreach (vt[i]) cyc(1'b0, vt[i].tms, vt[i].tdi, vt[i].bsr, 1'b1, vt[i].exp, $sformatf("vec%0d", i));

    // Five TMS=1 from Shift-DR must land in TLR with the reset instruction.
    load_ir(4'b0000);
    t(1'b1); t(1'b0); t(1'b0);
    for (int i = 0; i < 5; i++) t(1'b1);
    #2;
    chk1("tms5_ir_out", 32'(ir_out), 32'(TLR_IR));
    chk1("tms5_ctrl", {26'd0, TDO, TDO_EN, clockdr, shiftdr, updatedr, bs_en}, 32'd0);

    // RST overrides TMS=0 in the middle of a shift.
    load_ir(4'b0000);
    t(1'b1); t(1'b0); t(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11110, "pre_rst_shift");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, "");
    #2;
    chk1("midrst_ir_out", 32'(ir_out), 32'(TLR_IR));
    chk1("midrst_ctrl", {26'd0, TDO, TDO_EN, clockdr, shiftdr, updatedr, bs_en}, 32'd0);

    // Unknown opcode behaves as BYPASS.
    load_ir(4'b0110);
    #2;
    chk1("unk_ir_out", 32'(ir_out), 32'h6);
    chk1("unk_bs_en", 32'(bs_en), 32'd0);
    t(1'b1); t(1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, "unk_cap");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b01010, "unk_sh0");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11010, "unk_sh1");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, "unk_ex1");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, "unk_upd");

    // IDCODE scan: 32 bits LSB first (bypass-like without the ID register).
    pat = 32'hA5C3_0F96;
`ifdef JTAG_IDCODE_EN
    exp_id = IDV;
`else
    exp_id = {pat[30:0], 1'b0};
`endif
    load_ir(4'b0010);
    t(1'b1); t(1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, "id_cap");
    got = '0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, i == 31, pat[i], 1'b1, 1'b0, 5'd0, "");
      got[i] = last_tdo;
      chk1("id_clockdr", 32'(clockdr), 32'd0);
    end
    chk1("id_stream", got, exp_id);
    t(1'b1); t(1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 35,
          1'($urandom), 1'($urandom), 1'b0, 5'd0, "");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
